// File: rtl/sgd_mem_rd_splitter_pkg.sv
// ---------------------------------------------------------------------------
// sgd_rd_pkg
// Shared definitions for the training-data read path front end.
//   - Tag constants that identify which operand (A or B) a read belongs to.
//   - Field widths of the mem-cmd channel and of the tag.
//   - Splitter state encoding.
//   - burstChunk(): size of the next command so that it never crosses a
//     burst-aligned boundary.
// ---------------------------------------------------------------------------
package sgd_rd_pkg;

    localparam int TAG_W  = 8;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;

    localparam logic [TAG_W-1:0] MEM_RD_A_TAG = 8'h0a;
    localparam logic [TAG_W-1:0] MEM_RD_B_TAG = 8'h0b;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } splitState_e;

    // The distance to the next boundary can be the full burst size (up to
    // 2^32), which does not fit in LEN_W bits, so the comparison is done in
    // 33 bits. The result is never larger than 'remaining', so it always fits
    // back into LEN_W bits.
    function automatic logic [LEN_W-1:0] burstChunk(
        input logic [32:0]      addrLow,
        input logic [LEN_W-1:0] remaining,
        input logic [32:0]      maxBurst
    );
        logic [32:0] toBoundary;
        logic [32:0] remWide;
        toBoundary = maxBurst - (addrLow & (maxBurst - 33'd1));
        remWide    = {1'b0, remaining};
        return (remWide < toBoundary) ? remaining : toBoundary[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/sgd_mem_rd_splitter_if.sv
// ---------------------------------------------------------------------------
// sgd_mem_rd_splitter_if
// Bundles the three channels of the read splitter:
//   req_*    : one large read request (address, byte length, tag)
//   m_cmd_*  : aligned memory read commands
//   s_data_* : 512-bit data returned by memory
//   m_data_* : the same data forwarded downstream with its owning tag
// Modports:
//   slave  : the splitter's view (it serves read requests)
//   master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface sgd_mem_rd_splitter_if #(
    parameter int DATA_WIDTH = 512
);
    import sgd_rd_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_addr;
    logic [LEN_W-1:0]        req_length;
    logic [TAG_W-1:0]        req_tag;

    logic                    m_cmd_valid;
    logic                    m_cmd_ready;
    logic [ADDR_W-1:0]       m_cmd_address;
    logic [LEN_W-1:0]        m_cmd_length;

    logic                    s_data_valid;
    logic                    s_data_ready;
    logic [DATA_WIDTH-1:0]   s_data_data;
    logic [DATA_WIDTH/8-1:0] s_data_keep;
    logic                    s_data_last;

    logic                    m_data_valid;
    logic                    m_data_ready;
    logic [DATA_WIDTH-1:0]   m_data_data;
    logic [DATA_WIDTH/8-1:0] m_data_keep;
    logic                    m_data_last;
    logic [TAG_W-1:0]        m_data_tag;

    modport slave (
        input  req_valid, req_addr, req_length, req_tag,
        output req_ready,
        output m_cmd_valid, m_cmd_address, m_cmd_length,
        input  m_cmd_ready,
        input  s_data_valid, s_data_data, s_data_keep, s_data_last,
        output s_data_ready,
        output m_data_valid, m_data_data, m_data_keep, m_data_last, m_data_tag,
        input  m_data_ready
    );

    modport master (
        output req_valid, req_addr, req_length, req_tag,
        input  req_ready,
        input  m_cmd_valid, m_cmd_address, m_cmd_length,
        output m_cmd_ready,
        output s_data_valid, s_data_data, s_data_keep, s_data_last,
        input  s_data_ready,
        input  m_data_valid, m_data_data, m_data_keep, m_data_last, m_data_tag,
        output m_data_ready
    );

endinterface

// File: rtl/sgd_mem_rd_splitter_tag_fifo.sv
// ---------------------------------------------------------------------------
// sgd_tag_fifo
// Small synchronous first-word-fall-through FIFO holding the tag of every
// command that has been issued but whose data has not finished returning.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write pushData_i (ignored when full)
//   pushData_i    : tag to store
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry, valid whenever empty_o is low
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sgd_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // carries the extra bit that tells full apart from empty.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy bookkeeping is reset so that in-flight tags are forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/sgd_mem_rd_splitter.sv
// ---------------------------------------------------------------------------
// sgd_mem_rd_splitter
// Front end of the training-data read path. A single large read request is
// cut into memory read commands that never cross a MAX_BURST-aligned
// boundary. Returned data is passed straight through, labelled with the tag
// of the command that owns it. At most MAX_OUTSTANDING commands may have data
// still pending.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request, mem-cmd, memory data and downstream data channels
//   outstanding : number of commands issued whose last beat has not returned
//   busy        : a request is being split or data is still expected
// ---------------------------------------------------------------------------
module sgd_mem_rd_splitter
    import sgd_rd_pkg::*;
#(
    parameter int MAX_BURST       = 4096,
    parameter int MAX_OUTSTANDING = 16,
    parameter int DATA_WIDTH      = 512
) (
    input  logic                               clk,
    input  logic                               rst_n,
    sgd_mem_rd_splitter_if.slave               bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               busy
);

    localparam logic [32:0] BURST_33 = 33'(MAX_BURST);

    splitState_e       state_q, state_d;
    logic [ADDR_W-1:0] curAddr_q, curAddr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [TAG_W-1:0]  curTag_q, curTag_d;
    logic [LEN_W-1:0]  cmdLen_q, cmdLen_d;

    logic              reqFire;
    logic              cmdFire;
    logic              lastFire;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [TAG_W-1:0]  fifoHead;

    logic [DATA_WIDTH-1:0]   beatData;
    logic [DATA_WIDTH/8-1:0] beatKeep;

    assign reqFire  = bus.req_valid && (state_q == IDLE);
    assign cmdFire  = bus.m_cmd_valid && bus.m_cmd_ready;
    assign lastFire = bus.s_data_valid && bus.s_data_ready && bus.s_data_last;

    // Command channel. Address and length come straight from registers and
    // only change on a handshake, so they are stable while valid is high.
    // Valid can only drop through a handshake because the credit count never
    // rises without one.
    assign bus.req_ready     = (state_q == IDLE);
    assign bus.m_cmd_valid   = (state_q == ISSUE) && !fifoFull;
    assign bus.m_cmd_address = curAddr_q;
    assign bus.m_cmd_length  = cmdLen_q;

    // Data channel is a zero-latency pass-through. A beat is only let through
    // when a tag is waiting for it; otherwise it is held back in memory.
    assign beatData          = bus.s_data_data;
    assign beatKeep          = bus.s_data_keep;
    assign bus.m_data_valid  = bus.s_data_valid && !fifoEmpty;
    assign bus.s_data_ready  = bus.m_data_ready && !fifoEmpty;
    assign bus.m_data_data   = beatData;
    assign bus.m_data_keep   = beatKeep;
    assign bus.m_data_last   = bus.s_data_last;
    assign bus.m_data_tag    = fifoHead;

    assign busy = (state_q == ISSUE) || (outstanding != '0);

    // Next-state logic for the splitter. In IDLE a request loads the working
    // registers; a zero-length request is simply consumed. In ISSUE every
    // command handshake advances the address, shrinks the remaining length,
    // and returns to IDLE once the final piece has gone out. The address
    // wraps modulo 2^64 on purpose. The length of the next command is
    // precomputed from the updated values so the output is purely registered.
    always_comb begin
        state_d     = state_q;
        curAddr_d   = curAddr_q;
        remaining_d = remaining_q;
        curTag_d    = curTag_q;
        case (state_q)
            IDLE: begin
                if (reqFire) begin
                    curAddr_d   = bus.req_addr;
                    remaining_d = bus.req_length;
                    curTag_d    = bus.req_tag;
                    if (bus.req_length != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cmdFire) begin
                    curAddr_d   = curAddr_q + ADDR_W'(cmdLen_q);
                    remaining_d = remaining_q - cmdLen_q;
                    if (remaining_q == cmdLen_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmdLen_d = burstChunk(curAddr_d[32:0], remaining_d, BURST_33);
    end

    // Working registers of the splitter; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            curAddr_q   <= '0;
            remaining_q <= '0;
            curTag_q    <= '0;
            cmdLen_q    <= '0;
        end else begin
            state_q     <= state_d;
            curAddr_q   <= curAddr_d;
            remaining_q <= remaining_d;
            curTag_q    <= curTag_d;
            cmdLen_q    <= cmdLen_d;
        end
    end

    // One tag entry per issued command; the entry leaves when that command's
    // last data beat is handed downstream. Its occupancy is the credit count.
    sgd_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tagFifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (cmdFire),
        .pushData_i (curTag_q),
        .pop_i      (lastFire),
        .head_o     (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (outstanding)
    );

endmodule

// File: tb/tb_sgd_mem_rd_splitter.sv
// ---------------------------------------------------------------------------
// tb_sgd_mem_rd_splitter
// Directed bench for the read splitter: splitting, unaligned starts, address
// wrap, zero-length requests, credit limit, tagging, backpressure,
// simultaneous issue/retire and reset in the middle of a request.
// ---------------------------------------------------------------------------
module tb_sgd_mem_rd_splitter;
    import sgd_rd_pkg::*;

    localparam int DW = 512;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] outstanding;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sgd_mem_rd_splitter_if #(.DATA_WIDTH(DW)) bus ();

    sgd_mem_rd_splitter #(
        .MAX_BURST       (4096),
        .MAX_OUTSTANDING (16),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .busy        (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input of the splitter, then let the outputs settle.
    task automatic applyStimulus(input logic rv, input logic [63:0] ra, input logic [31:0] rl,
                                 input logic [7:0] rt, input logic cr, input logic dv,
                                 input logic dl, input logic dr, input logic [63:0] dw);
        bus.req_valid    = rv;
        bus.req_addr     = ra;
        bus.req_length   = rl;
        bus.req_tag      = rt;
        bus.m_cmd_ready  = cr;
        bus.s_data_valid = dv;
        bus.s_data_last  = dl;
        bus.m_data_ready = dr;
        bus.s_data_data  = {8{dw}};
        bus.s_data_keep  = '1;
        #1;
    endtask

    // Present a request while idle and let it be accepted on the next edge.
    task automatic acceptRequest(input string name, input logic [63:0] addr,
                                 input logic [31:0] len, input logic [7:0] tag);
        applyStimulus(1'b1, addr, len, tag, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput({name, "_req_ready"}, 64'(bus.req_ready), 64'h1);
        tick();
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    // Expect a command at the current sample point, then take it on the edge.
    task automatic expectCmd(input string name, input logic [63:0] addr,
                             input logic [31:0] len, input int expOut);
        checkOutput({name, "_valid"}, 64'(bus.m_cmd_valid), 64'h1);
        checkOutput({name, "_addr"}, bus.m_cmd_address, addr);
        checkOutput({name, "_len"}, 64'(bus.m_cmd_length), 64'(len));
        checkOutput({name, "_outstanding"}, 64'(outstanding), 64'(expOut));
        tick();
    endtask

    // Return n single-beat commands, each beat marked last.
    task automatic drainLast(input string name, input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA000 + 64'(i));
            checkOutput({name, "_dvalid"}, 64'(bus.m_data_valid), 64'h1);
            checkOutput({name, "_tag"}, 64'(bus.m_data_tag), 64'(tag));
            checkOutput({name, "_data"}, bus.m_data_data[511:448], 64'hA000 + 64'(i));
            tick();
        end
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        int beat;
        logic rdy;

        // Reset state, with a data beat offered and downstream ready.
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
        checkOutput("rst_cmd_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("rst_m_data_valid", 64'(bus.m_data_valid), 64'h0);
        checkOutput("rst_s_data_ready", 64'(bus.s_data_ready), 64'h0);
        checkOutput("rst_outstanding", 64'(outstanding), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'h1);
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        // Aligned request split into three commands on consecutive cycles.
        acceptRequest("t1", 64'h0, 32'h2800, MEM_RD_A_TAG);
        checkOutput("t1_busy", 64'(busy), 64'h1);
        checkOutput("t1_req_ready_low", 64'(bus.req_ready), 64'h0);
        expectCmd("t1_c0", 64'h0000, 32'h1000, 0);
        expectCmd("t1_c1", 64'h1000, 32'h1000, 1);
        expectCmd("t1_c2", 64'h2000, 32'h0800, 2);
        checkOutput("t1_done_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t1_done_outstanding", 64'(outstanding), 64'h3);
        checkOutput("t1_done_req_ready", 64'(bus.req_ready), 64'h1);
        drainLast("t1_drain", 3, MEM_RD_A_TAG);
        checkOutput("t1_drained", 64'(outstanding), 64'h0);
        checkOutput("t1_idle_busy", 64'(busy), 64'h0);

        // A beat with no tag waiting is held back, not dropped.
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hDEAD);
        checkOutput("stall_m_data_valid", 64'(bus.m_data_valid), 64'h0);
        checkOutput("stall_s_data_ready", 64'(bus.s_data_ready), 64'h0);
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

        // Unaligned start crossing one boundary.
        acceptRequest("t2", 64'hFC0, 32'h100, MEM_RD_B_TAG);
        expectCmd("t2_c0", 64'h0FC0, 32'h40, 0);
        expectCmd("t2_c1", 64'h1000, 32'hC0, 1);
        checkOutput("t2_done_valid", 64'(bus.m_cmd_valid), 64'h0);
        drainLast("t2_drain", 2, MEM_RD_B_TAG);

        // Zero-length request is consumed and issues nothing.
        applyStimulus(1'b1, 64'h5000, 32'h0, MEM_RD_A_TAG, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("zero_req_ready", 64'(bus.req_ready), 64'h1);
        tick();
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("zero_stays_idle", 64'(bus.req_ready), 64'h1);
        checkOutput("zero_no_cmd", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("zero_busy", 64'(busy), 64'h0);

        // Address wraps through the top of the 64-bit space.
        acceptRequest("wrap", 64'hFFFF_FFFF_FFFF_F000, 32'h2000, MEM_RD_A_TAG);
        expectCmd("wrap_c0", 64'hFFFF_FFFF_FFFF_F000, 32'h1000, 0);
        expectCmd("wrap_c1", 64'h0, 32'h1000, 1);
        drainLast("wrap_drain", 2, MEM_RD_A_TAG);

        // Credit limit: 16 commands, stall, one retire lets the 17th out.
        acceptRequest("t3", 64'h10000, 32'h14000, MEM_RD_A_TAG);
        for (int i = 0; i < 16; i++) begin
            expectCmd("t3_c", 64'h10000 + 64'(i) * 64'h1000, 32'h1000, i);
        end
        checkOutput("t3_stall_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t3_stall_outstanding", 64'(outstanding), 64'd16);
        tick();
        checkOutput("t3_stall_hold", 64'(bus.m_cmd_valid), 64'h0);
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hB000);
        checkOutput("t3_pop_cycle_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t3_pop_dvalid", 64'(bus.m_data_valid), 64'h1);
        tick();
        // From here each cycle both issues a command and retires one.
        expectCmd("t3_c16", 64'h20000, 32'h1000, 15);
        expectCmd("t5_same_cycle_c17", 64'h21000, 32'h1000, 15);
        expectCmd("t5_same_cycle_c18", 64'h22000, 32'h1000, 15);
        expectCmd("t5_same_cycle_c19", 64'h23000, 32'h1000, 15);
        checkOutput("t3_done_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t3_done_req_ready", 64'(bus.req_ready), 64'h1);
        checkOutput("t3_done_outstanding", 64'(outstanding), 64'd15);
        drainLast("t3_drain", 15, MEM_RD_A_TAG);
        checkOutput("t3_drained", 64'(outstanding), 64'h0);

        // Two back-to-back requests with different tags.
        acceptRequest("t4a", 64'h0, 32'h40, MEM_RD_A_TAG);
        expectCmd("t4a_c0", 64'h0, 32'h40, 0);
        acceptRequest("t4b", 64'h40, 32'h40, MEM_RD_B_TAG);
        expectCmd("t4b_c0", 64'h40, 32'h40, 1);
        checkOutput("t4_outstanding", 64'(outstanding), 64'h2);

        // Four beats (last on 2nd and 4th) under toggling downstream ready.
        beat = 0;
        for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
            rdy = cyc[0];
            applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b1, (beat == 1 || beat == 3), rdy,
                          64'h100 + 64'(beat));
            checkOutput("t5_s_data_ready", 64'(bus.s_data_ready), 64'(rdy));
            checkOutput("t4_tag", 64'(bus.m_data_tag), (beat < 2) ? 64'h0a : 64'h0b);
            checkOutput("t4_last", 64'(bus.m_data_last), 64'(beat == 1 || beat == 3));
            checkOutput("t4_data", bus.m_data_data[63:0], 64'h100 + 64'(beat));
            if (rdy) begin
                beat++;
            end
            tick();
        end
        checkOutput("t4_beats", 64'(beat), 64'd4);
        applyStimulus(1'b0, 64'h0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("t4_outstanding_end", 64'(outstanding), 64'h0);
        checkOutput("t4_busy_end", 64'(busy), 64'h0);

        // Reset after the first of three commands.
        acceptRequest("t6", 64'h3000, 32'h3000, MEM_RD_B_TAG);
        expectCmd("t6_c0", 64'h3000, 32'h1000, 0);
        checkOutput("t6_pre_valid", 64'(bus.m_cmd_valid), 64'h1);
        checkOutput("t6_pre_addr", bus.m_cmd_address, 64'h4000);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t6_rst_outstanding", 64'(outstanding), 64'h0);
        checkOutput("t6_rst_req_ready", 64'(bus.req_ready), 64'h1);
        tick();
        checkOutput("t6_next_valid", 64'(bus.m_cmd_valid), 64'h0);
        checkOutput("t6_next_outstanding", 64'(outstanding), 64'h0);
        checkOutput("t6_next_req_ready", 64'(bus.req_ready), 64'h1);
        rst_n = 1'b1;
        tick();
        acceptRequest("t6b", 64'h8000, 32'h40, MEM_RD_A_TAG);
        expectCmd("t6b_c0", 64'h8000, 32'h40, 0);
        checkOutput("t6b_done_valid", 64'(bus.m_cmd_valid), 64'h0);
        drainLast("t6b_drain", 1, MEM_RD_A_TAG);
        checkOutput("t6b_outstanding", 64'(outstanding), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
